pc_gshare: RTL and testbench

- Fetch-stage PC generator with a parametrised direction predictor and branch target buffer (BTB).
- Next generation of the single-level PC/BTB block: gshare indexing (PC XOR global history), configurable table depth, tag width, counter width and history length, BTB valid bits, and history checkpointing through the pipeline.
- Feeds the fetch address to IF/icache and accepts resolved-branch updates and redirects from EX.

---
 rtl/pc_gshare_pkg.sv | 16 +
 rtl/pc_gshare_tables.sv | 65 ++++++
 rtl/pc_gshare.sv | 123 ++++++++++++
 tb/tb_pc_gshare.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_gshare_pkg.sv
// rtl/pc_gshare_pkg.sv - shared types and helpers for the gshare PC generator
package pc_gshare_pkg;

  typedef enum logic [1:0] {
    NPC_REDIRECT,
    NPC_HOLD,
    NPC_PRED,
    NPC_SEQ
  } npc_sel_e;

  // Weakly not-taken: one below the taken threshold.
  function automatic int unsigned pht_init(int unsigned cnt_w);
    return (32'd1 << (cnt_w - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/pc_gshare_tables.sv
// rtl/pc_gshare_tables.sv - PHT and BTB arrays, one combinational read port, one synchronous write port
module pc_gshare_tables
  import pc_gshare_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 7,
  parameter int TAG_W  = 9,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_bidx,
  input  logic [IDX_W-1:0]  rd_gidx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [ADDR_W-1:0] rd_target,
  output logic              rd_taken,
  input  logic              wr_en,
  input  logic              wr_taken,
  input  logic [IDX_W-1:0]  wr_bidx,
  input  logic [IDX_W-1:0]  wr_gidx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [ADDR_W-1:0] wr_target
);

  localparam int DEPTH = 1 << IDX_W;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(pht_init(CNT_W));

  logic [DEPTH-1:0]  btb_valid;
  logic [TAG_W-1:0]  btb_tag    [DEPTH];
  logic [ADDR_W-1:0] btb_target [DEPTH];
  logic [CNT_W-1:0]  pht        [DEPTH];

  assign rd_valid  = btb_valid[rd_bidx];
  assign rd_tag    = btb_tag[rd_bidx];
  assign rd_target = btb_target[rd_bidx];
  assign rd_taken  = pht[rd_gidx][CNT_W-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btb_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pht[i] <= CNT_INIT;
      end
    end else if (wr_en) begin
      if (wr_taken) begin
        btb_valid[wr_bidx] <= 1'b1;
        if (pht[wr_gidx] != '1) begin
          pht[wr_gidx] <= pht[wr_gidx] + 1'b1;
        end
      end else if (pht[wr_gidx] != '0) begin
        pht[wr_gidx] <= pht[wr_gidx] - 1'b1;
      end
    end
  end

  // Tag/target payload needs no reset: the valid bit guards it.
  always_ff @(posedge clk) begin
    if (wr_en && wr_taken) begin
      btb_tag[wr_bidx]    <= wr_tag;
      btb_target[wr_bidx] <= wr_target;
    end
  end

endmodule

// File: rtl/pc_gshare.sv
// rtl/pc_gshare.sv - fetch PC generator with gshare direction predictor and BTB
module pc_gshare
  import pc_gshare_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 7,
  parameter int TAG_W  = 9,
  parameter int CNT_W  = 2,
  parameter int GHR_W  = 6,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              stall,
  input  logic              fetch_done,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic [GHR_W-1:0]  upd_ghr,
  output logic [ADDR_W-1:0] pc_o,
  output logic              pred_taken_o,
  output logic [GHR_W-1:0]  pred_ghr_o,
  output logic              flush_o
);

  localparam int TAG_LO = IDX_W + 2;
  localparam int TAG_HI = IDX_W + TAG_W + 1;

  logic [ADDR_W-1:0] pc_q;
  logic [GHR_W-1:0]  ghr_q;
  npc_sel_e          npc_sel;

  logic [IDX_W-1:0]  bidx, gidx, ubidx, ugidx;
  logic [TAG_W-1:0]  tag, utag;
  logic              rd_valid, rd_taken, hit;
  logic [TAG_W-1:0]  rd_tag;
  logic [ADDR_W-1:0] rd_target;
  logic [GHR_W-1:0]  ghr_restore;
  logic              unused_upd_pc;

  assign bidx  = pc_q[IDX_W+1:2];
  assign gidx  = bidx ^ IDX_W'(ghr_q);
  assign tag   = pc_q[TAG_HI:TAG_LO];
  // Training uses the history the branch was predicted with, not the live GHR.
  assign ubidx = upd_pc[IDX_W+1:2];
  assign ugidx = ubidx ^ IDX_W'(upd_ghr);
  assign utag  = upd_pc[TAG_HI:TAG_LO];

  assign unused_upd_pc = ^{upd_pc[1:0], upd_pc[ADDR_W-1:TAG_HI+1]};

  assign hit          = rd_valid && (rd_tag == tag);
  assign pred_taken_o = hit && rd_taken;
  assign pred_ghr_o   = ghr_q;
  assign pc_o         = pc_q;
  assign flush_o      = rdy && redirect_valid;

  assign ghr_restore = upd_valid ? GHR_W'((upd_ghr << 1) | GHR_W'(upd_taken)) : upd_ghr;

  pc_gshare_tables #(
    .ADDR_W (ADDR_W),
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W),
    .CNT_W  (CNT_W)
  ) u_tables (
    .clk       (clk),
    .rst       (rst),
    .rd_bidx   (bidx),
    .rd_gidx   (gidx),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_target (rd_target),
    .rd_taken  (rd_taken),
    .wr_en     (rdy && upd_valid),
    .wr_taken  (upd_taken),
    .wr_bidx   (ubidx),
    .wr_gidx   (ugidx),
    .wr_tag    (utag),
    .wr_target (upd_target)
  );

  always_comb begin
    npc_sel = NPC_SEQ;
    if (redirect_valid) begin
      npc_sel = NPC_REDIRECT;
    end else if (stall || !fetch_done) begin
      npc_sel = NPC_HOLD;
    end else if (pred_taken_o) begin
      npc_sel = NPC_PRED;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q  <= RESET_PC;
      ghr_q <= '0;
    end else if (rdy) begin
      case (npc_sel)
        NPC_REDIRECT: begin
          pc_q  <= redirect_pc;
          ghr_q <= ghr_restore;
        end
        NPC_PRED: begin
          pc_q  <= rd_target;
          ghr_q <= GHR_W'((ghr_q << 1) | GHR_W'(1));
        end
        NPC_SEQ: begin
          pc_q <= pc_q + ADDR_W'(4);
          // Only branches known to the BTB contribute a not-taken bit.
          if (hit) begin
            ghr_q <= GHR_W'(ghr_q << 1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_gshare.sv
// tb/tb_pc_gshare.sv - self-checking bench for pc_gshare
module tb_pc_gshare;

  localparam int ADDR_W = 32;
  localparam int IDX_W  = 7;
  localparam int TAG_W  = 9;
  localparam int CNT_W  = 2;
  localparam int GHR_W  = 6;
  localparam int DEPTH  = 1 << IDX_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              rdy = 1'b0;
  logic              stall = 1'b0;
  logic              fetch_done = 1'b0;
  logic              redirect_valid = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic              upd_valid = 1'b0;
  logic [ADDR_W-1:0] upd_pc = '0;
  logic              upd_taken = 1'b0;
  logic [ADDR_W-1:0] upd_target = '0;
  logic [GHR_W-1:0]  upd_ghr = '0;
  logic [ADDR_W-1:0] pc_o;
  logic              pred_taken_o;
  logic [GHR_W-1:0]  pred_ghr_o;
  logic              flush_o;

  always #5 clk = ~clk;

  pc_gshare #(
    .ADDR_W (ADDR_W), .IDX_W (IDX_W), .TAG_W (TAG_W),
    .CNT_W (CNT_W), .GHR_W (GHR_W), .RESET_PC ('0)
  ) dut (
    .clk (clk), .rst (rst), .rdy (rdy), .stall (stall), .fetch_done (fetch_done),
    .redirect_valid (redirect_valid), .redirect_pc (redirect_pc),
    .upd_valid (upd_valid), .upd_pc (upd_pc), .upd_taken (upd_taken),
    .upd_target (upd_target), .upd_ghr (upd_ghr),
    .pc_o (pc_o), .pred_taken_o (pred_taken_o), .pred_ghr_o (pred_ghr_o), .flush_o (flush_o)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: plain arrays indexed with integer arithmetic.
  bit          m_valid  [DEPTH];
  int          m_tag    [DEPTH];
  logic [31:0] m_target [DEPTH];
  int          m_cnt    [DEPTH];
  logic [31:0] m_pc;
  int          m_ghr;

  function automatic int bidx_of(logic [31:0] pc);
    return int'((pc / 4) % DEPTH);
  endfunction

  function automatic int tag_of(logic [31:0] pc);
    return int'((pc / (4 * DEPTH)) % (1 << TAG_W));
  endfunction

  function automatic bit model_hit();
    int b;
    b = bidx_of(m_pc);
    return m_valid[b] && (m_tag[b] == tag_of(m_pc));
  endfunction

  function automatic bit model_pred();
    int b;
    b = bidx_of(m_pc);
    return model_hit() && (m_cnt[b ^ m_ghr] >= (1 << (CNT_W - 1)));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 1'b0;
      m_cnt[i]   = (1 << (CNT_W - 1)) - 1;
    end
    m_pc  = '0;
    m_ghr = 0;
  endtask

  task automatic model_commit();
    int b, ub, ug, hist;
    bit hit, pt;
    if (!rdy) return;
    b   = bidx_of(m_pc);
    hit = model_hit();
    pt  = model_pred();
    if (redirect_valid) begin
      m_pc  = redirect_pc;
      m_ghr = upd_valid ? (int'(upd_ghr) * 2 + int'(upd_taken)) % (1 << GHR_W) : int'(upd_ghr);
    end else if (stall || !fetch_done) begin
      hist = m_ghr;
    end else if (pt) begin
      m_pc  = m_target[b];
      m_ghr = (m_ghr * 2 + 1) % (1 << GHR_W);
    end else begin
      m_pc = m_pc + 32'd4;
      if (hit) m_ghr = (m_ghr * 2) % (1 << GHR_W);
    end
    if (upd_valid) begin
      ub = bidx_of(upd_pc);
      ug = ub ^ int'(upd_ghr);
      if (upd_taken) begin
        m_valid[ub]  = 1'b1;
        m_tag[ub]    = tag_of(upd_pc);
        m_target[ub] = upd_target;
        if (m_cnt[ug] < (1 << CNT_W) - 1) m_cnt[ug] = m_cnt[ug] + 1;
      end else if (m_cnt[ug] > 0) begin
        m_cnt[ug] = m_cnt[ug] - 1;
      end
    end
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic check_all(string name, logic [31:0] epc, bit epred, int eghr);
    check({name, ".pc"}, pc_o, epc);
    check({name, ".pred"}, 32'(pred_taken_o), 32'(epred));
    check({name, ".ghr"}, 32'(pred_ghr_o), 32'(eghr));
    check({name, ".flush"}, 32'(flush_o), 32'(rdy && redirect_valid));
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  typedef struct {
    bit          rdy, stall, fd, rv;
    logic [31:0] rpc;
    bit          uv;
    logic [31:0] upc;
    bit          ut;
    logic [31:0] utgt;
    logic [5:0]  ughr;
    logic [31:0] epc;
    bit          epred;
    logic [5:0]  eghr;
  } vec_t;

  function automatic vec_t mk(bit r, bit s, bit f, bit rv, logic [31:0] rpc, bit uv,
                              logic [31:0] upc, bit ut, logic [31:0] utgt, logic [5:0] ughr,
                              logic [31:0] epc, bit epred, logic [5:0] eghr);
    vec_t v;
    v.rdy = r; v.stall = s; v.fd = f; v.rv = rv; v.rpc = rpc; v.uv = uv; v.upc = upc;
    v.ut = ut; v.utgt = utgt; v.ughr = ughr; v.epc = epc; v.epred = epred; v.eghr = eghr;
    return v;
  endfunction

  vec_t tbl [21];

  initial begin
    tbl[0]  = mk(1,0,1,0,0,     0,0,0,0,0,        32'h000,0,0);
    tbl[1]  = mk(1,0,1,0,0,     0,0,0,0,0,        32'h004,0,0);
    tbl[2]  = mk(1,0,1,0,0,     0,0,0,0,0,        32'h008,0,0);
    tbl[3]  = mk(1,0,1,0,0,     0,0,0,0,0,        32'h00C,0,0);
    tbl[4]  = mk(1,0,1,0,0,     1,32'h40,1,32'h100,0, 32'h010,0,0);
    tbl[5]  = mk(1,0,1,0,0,     1,32'h40,1,32'h100,0, 32'h014,0,0);
    tbl[6]  = mk(1,0,1,1,32'h40,0,0,0,0,0,        32'h018,0,0);
    tbl[7]  = mk(1,0,1,0,0,     0,0,0,0,0,        32'h040,1,0);
    tbl[8]  = mk(1,1,1,0,0,     1,32'h40,1,32'h100,0, 32'h100,0,1);
    tbl[9]  = mk(1,1,1,1,32'h40,1,32'h40,0,0,0,   32'h100,0,1);
    tbl[10] = mk(1,0,1,0,0,     0,0,0,0,0,        32'h040,1,0);
    tbl[11] = mk(1,1,1,1,32'h240,0,0,0,0,6'h2A,   32'h100,0,1);
    tbl[12] = mk(1,0,1,0,0,     0,0,0,0,0,        32'h240,0,6'h2A);
    tbl[13] = mk(0,0,1,1,32'h500,1,32'h40,0,0,0,  32'h244,0,6'h2A);
    tbl[14] = mk(0,0,1,1,32'h500,1,32'h40,0,0,0,  32'h244,0,6'h2A);
    tbl[15] = mk(0,0,1,1,32'h500,1,32'h40,0,0,0,  32'h244,0,6'h2A);
    tbl[16] = mk(1,0,1,1,32'h40,0,0,0,0,0,        32'h244,0,6'h2A);
    tbl[17] = mk(1,0,1,0,0,     0,0,0,0,0,        32'h040,1,0);
    tbl[18] = mk(1,0,0,0,0,     0,0,0,0,0,        32'h100,0,1);
    tbl[19] = mk(1,0,1,0,0,     0,0,0,0,0,        32'h100,0,1);
    tbl[20] = mk(1,0,1,0,0,     0,0,0,0,0,        32'h104,0,1);

    model_reset();
    #12;
    check_all("reset", 32'h0, 1'b0, 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 21; i++) begin
      rdy = tbl[i].rdy; stall = tbl[i].stall; fetch_done = tbl[i].fd;
      redirect_valid = tbl[i].rv; redirect_pc = tbl[i].rpc;
      upd_valid = tbl[i].uv; upd_pc = tbl[i].upc; upd_taken = tbl[i].ut;
      upd_target = tbl[i].utgt; upd_ghr = tbl[i].ughr;
      #1;
      check_all($sformatf("tbl%0d", i), tbl[i].epc, tbl[i].epred, int'(tbl[i].eghr));
      tick();
    end

    // Asynchronous reset between clock edges.
    rdy = 1; stall = 0; fetch_done = 1; redirect_valid = 0; upd_valid = 0;
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    check_all("midrst", 32'h0, 1'b0, 0);
    @(negedge clk);
    rst = 1'b1;
    redirect_valid = 1; redirect_pc = 32'h40; upd_ghr = '0;
    #1;
    tick();
    redirect_valid = 0;
    #1;
    check_all("midrst.0x40", 32'h40, 1'b0, 0);
    tick();

    for (int i = 0; i < 400; i++) begin
      rdy            = ($urandom_range(0, 9) != 0);
      stall          = ($urandom_range(0, 4) == 0);
      fetch_done     = ($urandom_range(0, 4) != 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc    = 32'($urandom_range(0, 255)) * 4;
      upd_valid      = ($urandom_range(0, 9) < 4);
      upd_pc         = 32'($urandom_range(0, 255)) * 4;
      upd_taken      = ($urandom_range(0, 2) != 0);
      upd_target     = 32'($urandom_range(0, 255)) * 4;
      upd_ghr        = 6'($urandom_range(0, 63));
      #1;
      check_all($sformatf("rnd%0d", i), m_pc, model_pred(), m_ghr);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
